// File: rtl/powlib_ipbankram.sv
// powlib_ipbankram: banked RAM behind a request stream, with reads answered in order through a response buffer.
// Define POWLIB_IPBANKRAM_ERRRESP_EN to answer bad non-write requests with an op 4'h2 response.
module powlib_ipbankram #(
   parameter int              B_BPD   = 2,
   parameter int              B_AW    = 16,
   parameter int              B_OPW   = 4,
   parameter logic [B_AW-1:0] B_BASE  = 16'h5555,
   parameter logic [B_AW-1:0] B_SIZE  = 16'h5554,
   parameter int              B_BANKS = 2,
   parameter int              RD_LAT  = 1,
   parameter int              OUT_D   = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [B_AW-1:0]                    wraddr,
   input  logic [8*B_BPD+B_BPD+B_OPW-1:0]     wrdata,
   input  logic                               wrvld,
   output logic                               wrrdy,
   output logic [B_AW-1:0]                    rdaddr,
   output logic [8*B_BPD+B_BPD+B_OPW-1:0]     rddata,
   output logic                               rdvld,
   input  logic                               rdrdy,
   output logic                               err
);
   localparam int B_DW  = 8*B_BPD;
   localparam int B_BEW = B_BPD;
   localparam int B_WW  = B_DW+B_BEW+B_OPW;
   localparam int DEPTH = int'(B_SIZE)+1;
   localparam int ROWS  = (DEPTH+B_BANKS-1)/B_BANKS;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BK_W  = (B_BANKS > 1) ? $clog2(B_BANKS) : 1;
   localparam int PW    = (OUT_D > 1) ? $clog2(OUT_D) : 1;
   localparam int CW    = $clog2(OUT_D+1);
   localparam logic [B_OPW-1:0] OP_WR  = B_OPW'(0);
   localparam logic [B_OPW-1:0] OP_RD  = B_OPW'(1);
   localparam logic [B_OPW-1:0] OP_ERR = B_OPW'(2);

   logic [B_OPW-1:0] op;
   logic [B_BEW-1:0] be;
   logic [B_DW-1:0]  dat;
   logic [B_AW-1:0]  ret, off;
   logic [BK_W-1:0]  bank;
   logic [RW-1:0]    row;
   logic             acc, in_rng, is_wr, is_rd, is_bad, resp_bad;

   always_comb begin
      op       = wrdata[B_WW-1 -: B_OPW];
      be       = wrdata[B_DW +: B_BEW];
      dat      = wrdata[B_DW-1:0];
      ret      = B_AW'(dat);
      off      = wraddr - B_BASE;
      in_rng   = (wraddr >= B_BASE) && (off <= B_SIZE);
      bank     = BK_W'(off % B_AW'(B_BANKS));
      row      = RW'(off / B_AW'(B_BANKS));
      acc      = wrvld && wrrdy;
      is_wr    = in_rng && (op == OP_WR);
      is_rd    = in_rng && (op == OP_RD);
      is_bad   = !is_wr && !is_rd;
`ifdef POWLIB_IPBANKRAM_ERRRESP_EN
      resp_bad = is_bad && (op != OP_WR);
`else
      resp_bad = 1'b0;
`endif
   end

   // Stage p0: bank write / registered bank read at acceptance
   logic [B_DW-1:0] bank_q [B_BANKS];

   for (genvar g = 0; g < B_BANKS; g++) begin : g_bank
      logic [B_DW-1:0] mem [ROWS];
      logic [B_DW-1:0] q;
      always_ff @(posedge clk) begin
         if (acc && is_wr && (bank == BK_W'(g))) begin
            for (int i = 0; i < B_BEW; i++) begin
               if (be[i]) mem[row][8*i +: 8] <= dat[8*i +: 8];
            end
         end
         if (acc && is_rd && (bank == BK_W'(g))) q <= mem[row];
      end
      assign bank_q[g] = q;
   end

   logic            vld_p0, bad_p0;
   logic [B_AW-1:0] ret_p0;
   logic [BK_W-1:0] bank_p0;
   logic [B_DW-1:0] word_p0;
   logic [B_WW-1:0] resp_p0;

   always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= acc && (is_rd || resp_bad);
   end

   always_ff @(posedge clk) begin
      bad_p0  <= resp_bad;
      ret_p0  <= ret;
      bank_p0 <= bank;
   end

   if (B_BANKS == 1) begin : g_one
      assign word_p0 = bank_q[0];
   end else begin : g_many
      assign word_p0 = bank_q[bank_p0];
   end

   always_comb begin
      if (bad_p0) resp_p0 = {OP_ERR, {B_BEW{1'b0}}, {B_DW{1'b0}}};
      else        resp_p0 = {OP_WR, {B_BEW{1'b1}}, word_p0};
   end

   logic                 push;
   logic [B_AW+B_WW-1:0] push_ent;
   logic [1:0]           infl;

   // Stage p1 (RD_LAT=2 only): extra memory output register
   if (RD_LAT == 2) begin : g_lat2
      logic            vld_p1;
      logic [B_WW-1:0] resp_p1;
      logic [B_AW-1:0] ret_p1;
      always_ff @(posedge clk) begin
         if (rst) vld_p1 <= 1'b0;
         else     vld_p1 <= vld_p0;
      end
      always_ff @(posedge clk) begin
         resp_p1 <= resp_p0;
         ret_p1  <= ret_p0;
      end
      assign push     = vld_p1;
      assign push_ent = {ret_p1, resp_p1};
      assign infl     = 2'(vld_p0) + 2'(vld_p1);
   end else begin : g_lat1
      assign push     = vld_p0;
      assign push_ent = {ret_p0, resp_p0};
      assign infl     = 2'(vld_p0);
   end

   // Response buffer: credit is reserved at acceptance, so push never meets a full buffer
   logic [B_AW+B_WW-1:0] fifo [OUT_D];
   logic [PW-1:0]        wp, rp;
   logic [CW-1:0]        cnt;
   logic                 pop, wrrdy_q;

   assign rdvld            = (cnt != '0);
   assign pop              = rdvld && rdrdy;
   assign {rdaddr, rddata} = fifo[rp];
   assign wrrdy            = wrrdy_q && !rst;

   always_ff @(posedge clk) begin
      if (push) fifo[wp] <= push_ent;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         cnt     <= '0;
         wrrdy_q <= 1'b1;
         err     <= 1'b0;
      end else begin
         if (push) wp <= (wp == PW'(OUT_D-1)) ? '0 : wp + 1'b1;
         if (pop)  rp <= (rp == PW'(OUT_D-1)) ? '0 : rp + 1'b1;
         cnt     <= cnt + CW'(push) - CW'(pop);
         wrrdy_q <= (OUT_D - int'(cnt) - int'(infl)) >= (RD_LAT + 1);
         if (acc && is_bad) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_powlib_ipbankram.sv
// Bench for powlib_ipbankram: timestamped response-queue model checked every cycle, plus directed literal checks.
module tb_powlib_ipbankram;
   localparam int          LAT  = 1;
   localparam logic [15:0] BASE = 16'h5555;
   localparam logic [15:0] SIZE = 16'h5554;
`ifdef POWLIB_IPBANKRAM_ERRRESP_EN
   localparam bit ERESP = 1'b1;
`else
   localparam bit ERESP = 1'b0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [21:0] d;
      int          t;
   } rsp_t;

   logic        clk, rst, wrvld, wrrdy, rdvld, rdrdy, err;
   logic [15:0] wraddr, rdaddr;
   logic [21:0] wrdata, rddata;
   logic        en2, wrvld2, wrrdy2, rdvld2, err2;
   logic [15:0] rdaddr2;
   logic [21:0] rddata2;

   int   n_chk = 0, n_fail = 0, ncyc = 0;
   rsp_t mq[$], got[$], q2[$];
   logic [15:0] mem_m [logic [15:0]];
   logic err_m = 1'b0;

   assign wrvld2 = wrvld & en2;

   powlib_ipbankram dut (
      .clk(clk), .rst(rst), .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
      .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy), .err(err)
   );

   powlib_ipbankram #(.B_BANKS(4), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld2), .wrrdy(wrrdy2),
      .rdaddr(rdaddr2), .rddata(rddata2), .rdvld(rdvld2), .rdrdy(1'b1), .err(err2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   function automatic void model_req(input logic [15:0] a, input logic [21:0] w);
      logic [3:0]  op;
      logic [1:0]  be;
      logic [15:0] d, cur;
      bit          inr;
      op  = w[21:18];
      be  = w[17:16];
      d   = w[15:0];
      inr = (a >= BASE) && (int'(a) <= int'(BASE) + int'(SIZE));
      if (inr && op == 4'h0) begin
         cur = mem_m.exists(a) ? mem_m[a] : 16'h0000;
         if (be[0]) cur[7:0]  = d[7:0];
         if (be[1]) cur[15:8] = d[15:8];
         mem_m[a] = cur;
      end else if (inr && op == 4'h1) begin
         mq.push_back('{d, {4'h0, 2'b11, mem_m[a]}, ncyc + LAT + 1});
      end else begin
         err_m = 1'b1;
         if (ERESP && op != 4'h0) mq.push_back('{d, {4'h2, 2'b00, 16'h0000}, ncyc + LAT + 1});
      end
   endfunction

   // Model: outputs of cycle n are compared, then that cycle's handshakes are applied
   initial begin
      bit exp_vld;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_vld = (mq.size() > 0) && (mq[0].t <= ncyc);
         chk("rdvld", rdvld, exp_vld);
         if (exp_vld && rdvld) begin
            chk("rdaddr", rdaddr, mq[0].a);
            chk("rddata", rddata, mq[0].d);
         end
         chk("err", err, err_m);
         if (rst) chk("wrrdy_in_rst", wrrdy, 1'b0);
         if (rdvld2) q2.push_back('{rdaddr2, rddata2, ncyc});
         if (rst) begin
            mq.delete();
            err_m = 1'b0;
         end else begin
            if (rdvld && rdrdy) begin
               got.push_back('{rdaddr, rddata, ncyc});
               if (exp_vld) void'(mq.pop_front());
            end
            if (wrvld && wrrdy) model_req(wraddr, wrdata);
         end
         ncyc++;
      end
   end

   task automatic idle(input int n);
      wrvld = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [1:0] be,
                       input logic [15:0] d, output int acyc);
      logic w;
      int   n;
      wraddr = a;
      wrdata = {op, be, d};
      wrvld  = 1'b1;
      acyc   = -1;
      n      = 0;
      do begin
         w = wrrdy;
         if (w) acyc = ncyc;
         @(posedge clk);
         #1;
         n++;
      end while (!w && n < 100);
      chk("send_accepted", w, 1'b1);
   endtask

   initial begin
      int ac, a0, g0, idx;
      logic w;
      rst = 1'b1; wrvld = 1'b0; wraddr = '0; wrdata = '0; rdrdy = 1'b1; en2 = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_rdvld", rdvld, 1'b0);
      chk("rst_wrrdy", wrrdy, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_wrrdy", wrrdy, 1'b1);

      // write then immediate read of the same word
      send(4'h0, 16'h5555, 2'b11, 16'hBEEF, ac);
      send(4'h1, 16'h5555, 2'b11, 16'h0010, ac);
      idle(6);
      chk("rd1_addr", got[got.size()-1].a, 16'h0010);
      chk("rd1_data", got[got.size()-1].d, {4'h0, 2'b11, 16'hBEEF});
      chk("rd1_latency", got[got.size()-1].t - ac, LAT + 1);

      // partial byte-enable write
      send(4'h0, 16'h5556, 2'b11, 16'h1234, ac);
      send(4'h0, 16'h5556, 2'b01, 16'hFFFF, ac);
      send(4'h1, 16'h5556, 2'b11, 16'h0020, ac);
      idle(6);
      chk("be_addr", got[got.size()-1].a, 16'h0020);
      chk("be_data", got[got.size()-1].d, {4'h0, 2'b11, 16'h12FF});

      // out-of-range read
      g0 = got.size();
      send(4'h1, 16'h0000, 2'b11, 16'h0044, ac);
      idle(6);
      chk("oor_err", err, 1'b1);
`ifdef POWLIB_IPBANKRAM_ERRRESP_EN
      chk("oor_resp_count", got.size() - g0, 1);
      chk("oor_resp_addr", got[got.size()-1].a, 16'h0044);
      chk("oor_resp_data", got[got.size()-1].d, {4'h2, 2'b00, 16'h0000});
`else
      chk("oor_resp_count", got.size() - g0, 0);
`endif

      // reset one cycle after a read is accepted
      send(4'h0, 16'h5560, 2'b11, 16'hA5A5, ac);
      g0 = got.size();
      send(4'h1, 16'h5560, 2'b11, 16'h0033, ac);
      wrvld = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_rdvld", rdvld, 1'b0);
      chk("midrst_err", err, 1'b0);
      chk("midrst_wrrdy", wrrdy, 1'b0);
      rst = 1'b0;
      idle(6);
      chk("midrst_dropped", got.size() - g0, 0);
      send(4'h1, 16'h5560, 2'b11, 16'h0034, ac);
      idle(6);
      chk("midrst_mem_kept", got[got.size()-1].d, {4'h0, 2'b11, 16'hA5A5});
      chk("midrst_addr", got[got.size()-1].a, 16'h0034);

      // back-pressure: 12 reads against a stalled consumer
      g0    = got.size();
      rdrdy = 1'b0;
      idx   = 0;
      for (int c = 0; c < 80 && idx < 12; c++) begin
         if (c == 20) begin
            chk("full_accepts", idx, 8);
            chk("full_wrrdy", wrrdy, 1'b0);
            chk("full_rdvld", rdvld, 1'b1);
            rdrdy = 1'b1;
         end
         wraddr = 16'h5555;
         wrdata = {4'h1, 2'b11, 16'h0100 + 16'(idx)};
         wrvld  = 1'b1;
         w = wrrdy;
         @(posedge clk);
         #1;
         if (w) idx++;
      end
      idle(20);
      chk("full_sent", idx, 12);
      chk("full_returned", got.size() - g0, 12);
      for (int i = 0; i < 12; i++) begin
         if (g0 + i < got.size()) begin
            chk("full_order", got[g0+i].a, 16'h0100 + 16'(i));
            chk("full_data", got[g0+i].d, {4'h0, 2'b11, 16'hBEEF});
         end
      end

      // alternating banks at full rate, also on the 4-bank / RD_LAT=2 instance
      en2 = 1'b1;
      send(4'h0, 16'h5555, 2'b11, 16'h1111, ac);
      send(4'h0, 16'h5556, 2'b11, 16'h2222, ac);
      g0 = got.size();
      q2.delete();
      a0 = 0;
      for (int i = 0; i < 16; i++) begin
         chk("alt_bk4_wrrdy", wrrdy2, 1'b1);
         send(4'h1, (i % 2 == 1) ? 16'h5556 : 16'h5555, 2'b11, 16'h0200 + 16'(i), ac);
         if (i == 0) a0 = ac;
         chk("alt_rate", ac, a0 + i);
      end
      idle(10);
      en2 = 1'b0;
      chk("alt_count", got.size() - g0, 16);
      chk("alt_bk4_count", q2.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (g0 + i < got.size()) begin
            chk("alt_addr", got[g0+i].a, 16'h0200 + 16'(i));
            chk("alt_data", got[g0+i].d, {4'h0, 2'b11, (i % 2 == 1) ? 16'h2222 : 16'h1111});
         end
         if (i < q2.size()) begin
            chk("alt_bk4_addr", q2[i].a, 16'h0200 + 16'(i));
            chk("alt_bk4_data", q2[i].d, {4'h0, 2'b11, (i % 2 == 1) ? 16'h2222 : 16'h1111});
         end
      end
      if (q2.size() > 0) chk("alt_bk4_latency", q2[0].t - a0, 3);
      chk("alt_bk4_err", err2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
